// File: rtl/coffee_order_sequencer_if.sv
// Signal bundle joining the host panel, coffee_order_sequencer and the vending machine core.
// master = sequencer side, slave = host/machine side.
interface coffee_order_sequencer_if #(
  parameter int CUP_W = 4
);
  // host side
  logic             start;
  logic [CUP_W-1:0] num_cups;
  logic             busy;
  logic             done;
  logic             error;
  logic [CUP_W-1:0] cups_served;
  logic [7:0]       coins_spent;
  // machine side
  logic             coin;
  logic             buy;
  logic             coffee;
  logic             refund;

  modport master (
    input  start, num_cups, coffee, refund,
    output coin, buy, busy, done, error, cups_served, coins_spent
  );

  modport slave (
    output start, num_cups, coffee, refund,
    input  coin, buy, busy, done, error, cups_served, coins_spent
  );
endinterface

// File: rtl/coffee_order_sequencer.sv
// Customer-side initiator for the coffee vending machine: inserts coins, issues buys, counts results.
// Optional feature: define ORDER_RETRY_EN to retry a cup after a refund (up to MAX_RETRY times).
module coffee_order_sequencer #(
  parameter int COINS_PER_CUP = 3,
  parameter int CUP_W         = 4,
  parameter int TIMEOUT       = 15,
  parameter int MAX_RETRY     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  coffee_order_sequencer_if.master bus
);

  // Coin counter holds 0..COINS_PER_CUP-1, timer holds 0..TIMEOUT-1.
  localparam int COIN_W  = (COINS_PER_CUP < 2) ? 1 : $clog2(COINS_PER_CUP);
  localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [COIN_W-1:0]  COIN_LAST  = COIN_W'(COINS_PER_CUP - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    INSERT,
    BUY,
    WAIT,
    DONE,
    ERR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [COIN_W-1:0]  coin_cnt;
  logic [TIMER_W-1:0] timer;
  logic [CUP_W-1:0]   num_cups_q;
  logic [CUP_W-1:0]   cups_served_q;
  logic [7:0]         coins_spent_q;
  logic               error_q;

  logic               accept;
  logic               cup_ok;

`ifdef ORDER_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_take;
`else
  // The retry limit only matters when retries exist; fold it away here.
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  // Next-state logic. coffee is tested before refund, so a simultaneous pair counts as coffee.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    accept    = 1'b0;
    cup_ok    = 1'b0;
`ifdef ORDER_RETRY_EN
    retry_take = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.num_cups == '0) ? DONE : INSERT;
        end
      end
      INSERT: begin
        if (coin_cnt == COIN_LAST) state_nxt = BUY;
      end
      BUY: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.coffee) begin
          cup_ok    = 1'b1;
          state_nxt = ((cups_served_q + CUP_W'(1)) == num_cups_q) ? DONE : INSERT;
        end else if (bus.refund) begin
`ifdef ORDER_RETRY_EN
          if (retry_cnt < RETRY_LIMIT) begin
            retry_take = 1'b1;
            state_nxt  = INSERT;
          end else begin
            state_nxt  = ERR;
          end
`else
          state_nxt = ERR;
`endif
        end else if (timer == TIMER_LAST) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the latched num_cups is reset too, so nothing is undefined after reset.
      state         <= IDLE;
      coin_cnt      <= '0;
      timer         <= '0;
      num_cups_q    <= '0;
      cups_served_q <= '0;
      coins_spent_q <= '0;
      error_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state <= state_nxt;

      // Coin counter runs only while INSERT continues, so it is zero on every entry.
      if (state == INSERT && state_nxt == INSERT) coin_cnt <= coin_cnt + COIN_W'(1);
      else                                        coin_cnt <= '0;

      if (state == WAIT) timer <= timer + TIMER_W'(1);
      else               timer <= '0;

      if (accept) begin
        num_cups_q    <= bus.num_cups;
        cups_served_q <= '0;
        coins_spent_q <= '0;
        error_q       <= 1'b0;
      end else begin
        if (cup_ok) cups_served_q <= cups_served_q + CUP_W'(1);
        if (state == INSERT && coins_spent_q != 8'hFF) coins_spent_q <= coins_spent_q + 8'd1;
        if (state_nxt == ERR) error_q <= 1'b1;
      end
    end
  end

`ifdef ORDER_RETRY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                  retry_cnt <= '0;
    else if (accept || cup_ok)   retry_cnt <= '0;
    else if (retry_take)         retry_cnt <= retry_cnt + RETRY_W'(1);
  end
`endif

  // Moore outputs decoded from the state register.
  assign bus.coin        = (state == INSERT);
  assign bus.buy         = (state == BUY);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE) || (state == ERR);
  assign bus.error       = error_q;
  assign bus.cups_served = cups_served_q;
  assign bus.coins_spent = coins_spent_q;

endmodule
